// File: rtl/proc_pkg.sv
// Shared definitions for the fetch/decode front end: opcodes, instruction
// field positions, FSM state encoding and default widths.
package proc_pkg;

  localparam int PC_W_DEF   = 4;
  localparam int INST_W_DEF = 16;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS_MSB  = 8;
  localparam int RS_LSB  = 6;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 0;
  localparam int TGT_MSB = 11;
  localparam int TGT_LSB = 8;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_SUBI = 4'hB;
  localparam logic [3:0] OP_BR   = 4'hC;
  localparam logic [3:0] OP_MOV  = 4'hE;
  localparam logic [3:0] OP_OUT  = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  function automatic logic op_defined(input logic [3:0] op);
    case (op)
      OP_NOP, OP_LOAD, OP_ADD, OP_SUB, OP_JMP,
      OP_ADDI, OP_SUBI, OP_BR, OP_MOV, OP_OUT: op_defined = 1'b1;
      default:                                 op_defined = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/inst_fields.sv
// Combinational instruction field extraction and classification of the
// opcodes that the fetch unit resolves by itself.
import proc_pkg::*;

module inst_fields #(
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic [INST_W-1:0] ir,
  output logic [3:0]        op,
  output logic [2:0]        rd,
  output logic [2:0]        rs,
  output logic [8:0]        imm,
  output logic [PC_W-1:0]   target,
  output logic              is_nop,
  output logic              is_jmp,
  output logic              is_br,
  output logic              is_undef
);

  assign op     = ir[OP_MSB:OP_LSB];
  assign rd     = ir[RD_MSB:RD_LSB];
  assign rs     = ir[RS_MSB:RS_LSB];
  assign imm    = ir[IMM_MSB:IMM_LSB];
  assign target = PC_W'(ir[TGT_MSB:TGT_LSB]);

  assign is_nop   = (op == OP_NOP);
  assign is_jmp   = (op == OP_JMP);
  assign is_br    = (op == OP_BR);
  assign is_undef = !op_defined(op);

endmodule

// File: rtl/fetch_decode.sv
// Instruction fetch/decode unit: owns the PC, resolves nop/jmp/br locally and
// issues other instructions over valid/ready. Option: FETCH_ILLEGAL_TRAP_EN.
import proc_pkg::*;

module fetch_decode #(
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [PC_W-1:0]   rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              zero_flag,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [3:0]        dec_op,
  output logic [2:0]        dec_rd,
  output logic [2:0]        dec_rs,
  output logic [8:0]        dec_imm,
  output logic [PC_W-1:0]   dec_pc
`ifdef FETCH_ILLEGAL_TRAP_EN
  ,
  output logic              illegal
`endif
);

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INST_W-1:0]   ir_q, ir_d;
  logic [PC_W-1:0]     pc_inc;
  logic [PC_W-1:0]     f_target;
  logic                f_is_nop, f_is_jmp, f_is_br, f_is_undef;

  inst_fields #(
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_fields (
    .ir       (ir_q),
    .op       (dec_op),
    .rd       (dec_rd),
    .rs       (dec_rs),
    .imm      (dec_imm),
    .target   (f_target),
    .is_nop   (f_is_nop),
    .is_jmp   (f_is_jmp),
    .is_br    (f_is_br),
    .is_undef (f_is_undef)
  );

  assign pc_inc   = pc_q + PC_W'(1);
  assign rom_addr = pc_q;
  assign dec_pc   = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    dec_valid = 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
    illegal   = 1'b0;
`endif
    case (state_q)
      ST_FETCH: begin
        if (run) begin
          ir_d    = rom_inst;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_FETCH;
        if (f_is_jmp) begin
          pc_d = f_target;
        end else if (f_is_br) begin
          pc_d = zero_flag ? f_target : pc_inc;
`ifdef FETCH_ILLEGAL_TRAP_EN
        end else if (f_is_undef) begin
          // PC stays on the offending word so it can be inspected after the trap
          illegal = 1'b1;
          state_d = ST_HALT;
        end else if (f_is_nop) begin
          pc_d = pc_inc;
`else
        end else if (f_is_nop || f_is_undef) begin
          pc_d = pc_inc;
`endif
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        dec_valid = 1'b1;
        if (dec_ready) begin
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end
      end
`ifdef FETCH_ILLEGAL_TRAP_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: directed scenarios plus a randomized
// program checked against an instruction-level reference model.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [3:0]  rom_addr;
  logic [15:0] rom_inst;
  logic        zero_flag;
  logic        dec_valid;
  logic        dec_ready;
  logic [3:0]  dec_op;
  logic [2:0]  dec_rd;
  logic [2:0]  dec_rs;
  logic [8:0]  dec_imm;
  logic [3:0]  dec_pc;
`ifdef FETCH_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  logic [15:0] rom [16];
  int tests = 0;
  int fails = 0;

  assign rom_inst = rom[rom_addr];
  always #5 clk = ~clk;

  fetch_decode #(.PC_W(4), .INST_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .rom_addr  (rom_addr),
    .rom_inst  (rom_inst),
    .zero_flag (zero_flag),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec_op    (dec_op),
    .dec_rd    (dec_rd),
    .dec_rs    (dec_rs),
    .dec_imm   (dec_imm),
    .dec_pc    (dec_pc)
`ifdef FETCH_ILLEGAL_TRAP_EN
    ,
    .illegal   (illegal)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom;
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset;
    rst = 1'b1; run = 1'b1; dec_ready = 1'b1; zero_flag = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clear_rom;
    rom[0] = 16'h8500; rom[5] = 16'h2A4F;
    do_reset;
    dec_ready = 1'b0;
    tick; tick; tick; tick;
    tests++; if (dec_valid !== 1'b1) begin fails++; $display("FAIL pre_reset_valid: got %0b expected 1", dec_valid); end
    #3 rst = 1'b1;
    #1;
    tests++; if (dec_valid !== 1'b0) begin fails++; $display("FAIL async_reset_valid: got %0b expected 0", dec_valid); end
    tests++; if (rom_addr !== 4'd0) begin fails++; $display("FAIL reset_rom_addr: got %0h expected 0", rom_addr); end
    tests++; if ({dec_op, dec_rd, dec_rs, dec_imm, dec_pc} !== 23'd0) begin fails++; $display("FAIL reset_fields: got op=%0h rd=%0h rs=%0h imm=%0h pc=%0h expected all 0", dec_op, dec_rd, dec_rs, dec_imm, dec_pc); end
`ifdef FETCH_ILLEGAL_TRAP_EN
    tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL reset_illegal: got %0b expected 0", illegal); end
`endif
    tick;
    rst = 1'b0;
  endtask

  task automatic test_first_issue;
    clear_rom;
    rom[0] = 16'hB401;
    do_reset;
    tests++; if (rom_addr !== 4'd0 || dec_valid !== 1'b0) begin fails++; $display("FAIL issue_c0: got addr=%0h valid=%0b expected 0/0", rom_addr, dec_valid); end
    tick;
    tests++; if (dec_valid !== 1'b0) begin fails++; $display("FAIL issue_c1_valid: got %0b expected 0", dec_valid); end
    tick;
    tests++; if (dec_valid !== 1'b1) begin fails++; $display("FAIL issue_c2_valid: got %0b expected 1", dec_valid); end
    tests++; if (dec_op !== 4'hB || dec_rd !== 3'd2 || dec_imm !== 9'd1 || dec_pc !== 4'd0) begin fails++; $display("FAIL issue_c2_fields: got op=%0h rd=%0h imm=%0h pc=%0h expected b/2/1/0", dec_op, dec_rd, dec_imm, dec_pc); end
    tick;
    tests++; if (rom_addr !== 4'd1 || dec_valid !== 1'b0) begin fails++; $display("FAIL issue_c3: got addr=%0h valid=%0b expected 1/0", rom_addr, dec_valid); end
  endtask

  task automatic test_jmp;
    clear_rom;
    rom[0] = 16'h8400; rom[4] = 16'h8300;
    do_reset;
    tick; tick;
    tests++; if (rom_addr !== 4'd4) begin fails++; $display("FAIL jmp_reach4: got %0h expected 4", rom_addr); end
    tick;
    tests++; if (dec_valid !== 1'b0) begin fails++; $display("FAIL jmp_valid: got %0b expected 0", dec_valid); end
    tick;
    tests++; if (rom_addr !== 4'd3) begin fails++; $display("FAIL jmp_target: got %0h expected 3", rom_addr); end
  endtask

  task automatic test_br;
    for (int z = 0; z < 2; z++) begin
      clear_rom;
      rom[0] = 16'h8400; rom[4] = 16'hCA00;
      do_reset;
      tick; tick;
      zero_flag = (z == 0);
      tick;
      zero_flag = (z == 1);
      tick;
      zero_flag = (z == 0);
      tests++; if (rom_addr !== ((z == 1) ? 4'd10 : 4'd5)) begin fails++; $display("FAIL br_z%0d: got %0h expected %0h", z, rom_addr, (z == 1) ? 10 : 5); end
    end
  endtask

  task automatic test_stall;
    clear_rom;
    rom[0] = 16'h8200; rom[2] = 16'h228F;
    do_reset;
    dec_ready = 1'b0;
    tick; tick; tick; tick;
    for (int k = 0; k < 6; k++) begin
      tests++; if (dec_valid !== 1'b1 || dec_op !== 4'h2 || dec_rd !== 3'd1 || dec_rs !== 3'd2 || rom_addr !== 4'd2 || dec_pc !== 4'd2) begin
        fails++; $display("FAIL stall_k%0d: got valid=%0b op=%0h rd=%0h rs=%0h addr=%0h pc=%0h expected 1/2/1/2/2/2", k, dec_valid, dec_op, dec_rd, dec_rs, rom_addr, dec_pc);
      end
      zero_flag = 1'($urandom);
      if (k == 2) run = 1'b0;
      if (k == 5) dec_ready = 1'b1;
      tick;
    end
    tests++; if (dec_valid !== 1'b0 || rom_addr !== 4'd3) begin fails++; $display("FAIL stall_done: got valid=%0b addr=%0h expected 0/3", dec_valid, rom_addr); end
    tick; tick;
    tests++; if (dec_valid !== 1'b0 || rom_addr !== 4'd3) begin fails++; $display("FAIL run_low_hold: got valid=%0b addr=%0h expected 0/3", dec_valid, rom_addr); end
    run = 1'b1;
  endtask

  task automatic test_wrap;
    clear_rom;
    rom[0] = 16'h8F00; rom[15] = 16'h0000;
    do_reset;
    tick; tick;
    tests++; if (rom_addr !== 4'd15) begin fails++; $display("FAIL wrap_reach15: got %0h expected f", rom_addr); end
    tick;
    tests++; if (dec_valid !== 1'b0) begin fails++; $display("FAIL wrap_valid: got %0b expected 0", dec_valid); end
    tick;
    tests++; if (rom_addr !== 4'd0) begin fails++; $display("FAIL wrap_addr: got %0h expected 0", rom_addr); end
  endtask

  task automatic test_illegal;
    clear_rom;
    rom[0] = 16'h8600; rom[6] = 16'h4000;
    do_reset;
    tick; tick;
    tests++; if (rom_addr !== 4'd6) begin fails++; $display("FAIL illegal_reach6: got %0h expected 6", rom_addr); end
    tick;
`ifdef FETCH_ILLEGAL_TRAP_EN
    tests++; if (illegal !== 1'b1) begin fails++; $display("FAIL illegal_pulse: got %0b expected 1", illegal); end
    for (int k = 0; k < 20; k++) begin
      tick;
      tests++; if (illegal !== 1'b0 || dec_valid !== 1'b0 || rom_addr !== 4'd6) begin fails++; $display("FAIL halt_k%0d: got illegal=%0b valid=%0b addr=%0h expected 0/0/6", k, illegal, dec_valid, rom_addr); end
    end
`else
    tick;
    tests++; if (rom_addr !== 4'd7 || dec_valid !== 1'b0) begin fails++; $display("FAIL undef_as_nop: got addr=%0h valid=%0b expected 7/0", rom_addr, dec_valid); end
`endif
  endtask

  task automatic test_random;
    logic [3:0]  ops [$];
    logic [3:0]  pc_m;
    logic [15:0] inst;
    logic [3:0]  op;
    logic        zf, r;
    int          hold, waits;
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'hA, 4'hB, 4'hC, 4'hE, 4'hF};
`ifndef FETCH_ILLEGAL_TRAP_EN
    ops.push_back(4'h4); ops.push_back(4'h5); ops.push_back(4'h6);
    ops.push_back(4'h7); ops.push_back(4'h9); ops.push_back(4'hD);
`endif
    for (int i = 0; i < 16; i++) rom[i] = {ops[$urandom_range(0, ops.size() - 1)], 12'($urandom)};
    do_reset;
    pc_m = 4'd0;
    for (int n = 0; n < 200; n++) begin
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run = 1'b0;
      for (int h = 0; h < hold; h++) begin
        zero_flag = 1'($urandom);
        tick;
        tests++; if (rom_addr !== pc_m || dec_valid !== 1'b0) begin fails++; $display("FAIL rnd_hold n=%0d: got addr=%0h valid=%0b expected %0h/0", n, rom_addr, dec_valid, pc_m); end
      end
      run = 1'b1;
      tests++; if (rom_addr !== pc_m) begin fails++; $display("FAIL rnd_fetch n=%0d: got addr=%0h expected %0h", n, rom_addr, pc_m); end
      inst = rom[pc_m];
      op = inst[15:12];
      zero_flag = 1'($urandom);
      tick;
      tests++; if (dec_valid !== 1'b0) begin fails++; $display("FAIL rnd_decode_valid n=%0d: got %0b expected 0", n, dec_valid); end
      zf = 1'($urandom);
      zero_flag = zf;
      run = 1'($urandom);
      tick;
      case (op)
        4'h8: pc_m = inst[11:8];
        4'hC: pc_m = zf ? inst[11:8] : pc_m + 4'd1;
        4'h1, 4'h2, 4'h3, 4'hA, 4'hB, 4'hE, 4'hF: begin
          waits = 0;
          do begin
            tests++; if (dec_valid !== 1'b1 || dec_op !== op || dec_rd !== inst[11:9] || dec_rs !== inst[8:6] || dec_imm !== inst[8:0] || dec_pc !== pc_m) begin
              fails++; $display("FAIL rnd_issue n=%0d: got valid=%0b op=%0h rd=%0h rs=%0h imm=%0h pc=%0h expected inst %04h at %0h", n, dec_valid, dec_op, dec_rd, dec_rs, dec_imm, dec_pc, inst, pc_m);
            end
            r = (waits >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
            dec_ready = r;
            zero_flag = 1'($urandom);
            run = 1'($urandom);
            tick;
            waits++;
          end while (!r);
          pc_m = pc_m + 4'd1;
        end
        default: pc_m = pc_m + 4'd1;
      endcase
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; dec_ready = 1'b0; zero_flag = 1'b0;
    clear_rom;
    test_reset;
    test_first_issue;
    test_jmp;
    test_br;
    test_stall;
    test_wrap;
    test_illegal;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
